// File: rtl/seq_detect_param.sv
// Parameterised KMP sequence detector: Mealy match flag, registered progress, saturating match count.
// Optional match counter is compiled in with macro SEQ_DETECT_PARAM_CNT_EN; otherwise match_cnt is tied to 0.
module seq_detect_param #(
    parameter int SYM_W   = 1,
    parameter int PAT_LEN = 5,
    parameter     PATTERN = 5'b00111,
    parameter int CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           din_valid,
    input  logic [SYM_W-1:0]               din,
    input  logic                           overlap_en,
    output logic                           pattern,
    output logic [$clog2(PAT_LEN+1)-1:0]   progress,
    output logic [CNT_W-1:0]               match_cnt
);

    localparam int PW  = $clog2(PAT_LEN + 1);
    localparam int TBL = 1 << PW;

    typedef logic [TBL-1:0][SYM_W-1:0] sym_tbl_t;
    typedef logic [TBL-1:0][PW-1:0]    fail_tbl_t;

    if (SYM_W < 1 || SYM_W > 8) begin : g_bad_sym_w
        $error("seq_detect_param: SYM_W must be in 1..8");
    end
    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
        $error("seq_detect_param: PAT_LEN must be in 2..16");
    end
    if ($bits(PATTERN) != PAT_LEN * SYM_W) begin : g_bad_pattern
        $error("seq_detect_param: PATTERN width must equal PAT_LEN*SYM_W");
    end

    // Entry i holds pattern symbol i (symbol 0 is the first one received).
    function automatic sym_tbl_t build_syms();
        sym_tbl_t t;
        t = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            t[i] = PATTERN[(PAT_LEN-1-i)*SYM_W +: SYM_W];
        end
        return t;
    endfunction

    // Entry n = longest proper prefix-suffix length of the first n pattern symbols.
    function automatic fail_tbl_t build_fail(input sym_tbl_t s);
        fail_tbl_t      f;
        logic [PW-1:0]  k;
        logic [PW-1:0]  ii;
        f = '0;
        k = '0;
        for (int i = 1; i < PAT_LEN; i++) begin
            ii = PW'(i);
            for (int j = 0; j < PAT_LEN; j++) begin
                if (k != '0 && s[ii] != s[k]) begin
                    k = f[k];
                end
            end
            if (s[ii] == s[k]) begin
                k = k + PW'(1);
            end
            f[PW'(i + 1)] = k;
        end
        return f;
    endfunction

    localparam sym_tbl_t      SYMS     = build_syms();
    localparam fail_tbl_t     FAIL     = build_fail(SYMS);
    localparam logic [PW-1:0] LAST     = PW'(PAT_LEN - 1);
    localparam logic [PW-1:0] FULL_LPS = FAIL[PAT_LEN];

    logic [PW-1:0] progress_q;
    logic [PW-1:0] progress_d;
    logic [PW-1:0] k_s;
    logic          match_s;

    assign match_s  = din_valid && (progress_q == LAST) && (din == SYMS[LAST]);
    assign progress = progress_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            progress_q <= '0;
        end else begin
            progress_q <= progress_d;
        end
    end

    // Next state: follow the failure chain until din extends a prefix or the chain bottoms out.
    always_comb begin
        progress_d = progress_q;
        k_s        = progress_q;
        if (!din_valid) begin
            progress_d = progress_q;
        end else if (match_s) begin
            progress_d = overlap_en ? FULL_LPS : '0;
        end else begin
            for (int j = 0; j < PAT_LEN; j++) begin
                if (k_s != '0 && SYMS[k_s] != din) begin
                    k_s = FAIL[k_s];
                end else begin
                    k_s = k_s;
                end
            end
            if (SYMS[k_s] == din) begin
                progress_d = k_s + PW'(1);
            end else begin
                progress_d = '0;
            end
        end
    end

    // Mealy output, forced low during reset.
    always_comb begin
        pattern = 1'b0;
        if (!rst && match_s) begin
            pattern = 1'b1;
        end else begin
            pattern = 1'b0;
        end
    end

`ifdef SEQ_DETECT_PARAM_CNT_EN
    logic [CNT_W-1:0] match_cnt_q;
    logic [CNT_W-1:0] match_cnt_d;

    // Saturating match counter next value.
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (match_s && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt = match_cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised + directed bench for seq_detect_param; two instances (default BBCCC and 0101 with 2-bit counter)
// checked against a symbol-history reference model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [0:0] din;
    logic       overlap_en;

    logic       pat5_o;
    logic [2:0] prog5_o;
    logic [7:0] cnt5_o;
    logic       pat4_o;
    logic [2:0] prog4_o;
    logic [1:0] cnt4_o;

    int checks   = 0;
    int failures = 0;

    int P5[$] = {0, 0, 1, 1, 1};
    int P4[$] = {0, 1, 0, 1};
    int h5[$];
    int h4[$];
    int mcnt5 = 0;
    int mcnt4 = 0;

    always #5 clk = ~clk;

    seq_detect_param dut5 (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .overlap_en (overlap_en),
        .pattern    (pat5_o),
        .progress   (prog5_o),
        .match_cnt  (cnt5_o)
    );

    seq_detect_param #(
        .SYM_W   (1),
        .PAT_LEN (4),
        .PATTERN (4'b0101),
        .CNT_W   (2)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .overlap_en (overlap_en),
        .pattern    (pat4_o),
        .progress   (prog4_o),
        .match_cnt  (cnt4_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Longest suffix of the history (shorter than the pattern) that equals a pattern prefix.
    function automatic int prog_of(input int h[$], input int pat[$]);
        int best = 0;
        for (int k = 1; k < pat.size(); k++) begin
            if (k <= h.size()) begin
                bit ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[h.size() - k + j] != pat[j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // True when history followed by sym ends with the full pattern.
    function automatic bit is_match(input int h[$], input int pat[$], input int sym);
        int n = pat.size();
        if (h.size() + 1 < n) return 1'b0;
        if (sym != pat[n-1]) return 1'b0;
        for (int j = 0; j < n - 1; j++) begin
            if (h[h.size() - (n - 1) + j] != pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef SEQ_DETECT_PARAM_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic cycle(input bit r, input bit v, input bit d, input bit o);
        bit m5;
        bit m4;
        rst        = r;
        din_valid  = v;
        din        = d;
        overlap_en = o;
        @(negedge clk);
        m5 = !r && v && is_match(h5, P5, int'(d));
        m4 = !r && v && is_match(h4, P4, int'(d));
        check("pattern5", int'(pat5_o), int'(m5));
        check("pattern4", int'(pat4_o), int'(m4));
        @(posedge clk);
        #1;
        if (r) begin
            h5.delete();
            h4.delete();
            mcnt5 = 0;
            mcnt4 = 0;
        end else if (v) begin
            h5.push_back(int'(d));
            h4.push_back(int'(d));
            while (h5.size() > P5.size()) void'(h5.pop_front());
            while (h4.size() > P4.size()) void'(h4.pop_front());
            if (m5) begin
                if (mcnt5 < 255) mcnt5++;
                if (!o) h5.delete();
            end
            if (m4) begin
                if (mcnt4 < 3) mcnt4++;
                if (!o) h4.delete();
            end
        end
        check("progress5", int'(prog5_o), prog_of(h5, P5));
        check("progress4", int'(prog4_o), prog_of(h4, P4));
        check("match_cnt5", int'(cnt5_o), exp_cnt(mcnt5));
        check("match_cnt4", int'(cnt4_o), exp_cnt(mcnt4));
    endtask

    task automatic seq(input int bits[$], input bit o);
        foreach (bits[i]) cycle(1'b0, 1'b1, bits[i][0], o);
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = 1'b0;
        overlap_en = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, then the canonical match.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_progress5", int'(prog5_o), 0);
        check("reset_cnt5", int'(cnt5_o), 0);
        seq('{0, 0, 1, 1, 1}, 1'b1);

        // Extra leading B keeps progress at 2.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        seq('{0, 0, 0, 1, 1, 1}, 1'b1);

        // Overlapping vs non-overlapping 0101.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        seq('{0, 1, 0, 1, 0, 1}, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        seq('{0, 1, 0, 1, 0, 1}, 1'b0);

        // Idle gap with din matching the last symbol.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        seq('{0, 0}, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("gap_progress5", int'(prog5_o), 2);
        seq('{1, 1, 1}, 1'b1);

        // Reset mid-sequence discards the partial match.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        seq('{0, 0, 1}, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("midreset_progress5", int'(prog5_o), 0);
        seq('{1, 1}, 1'b1);

        // Five back-to-back overlapping matches saturate the 2-bit counter.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        seq('{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1}, 1'b1);
        check("sat_cnt4", int'(cnt4_o), exp_cnt(3));

        // Randomised traffic with occasional resets and overlap toggling.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 4) != 0),
                  1'($urandom()),
                  1'($urandom()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter SYM_W, default 1: symbol width in bits, range 1..8.
REQ-002 SHALL have parameter PAT_LEN, default 5: pattern length in symbols, range 2..16.
REQ-003 SHALL have parameter PATTERN, default 5'b00111 (B=0, C=1, i.e. BBCCC): PAT_LEN*SYM_W bits; the first symbol is in the most significant SYM_W bits.
REQ-004 SHALL have parameter CNT_W, default 8: match counter width.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-007 SHALL have port din_valid  input  1: din carries a symbol this cycle.
REQ-008 SHALL have port din  input  SYM_W: input symbol.
REQ-009 SHALL have port overlap_en  input  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port pattern  output  1: Mealy match flag.
REQ-011 SHALL have port progress  output  $clog2(PAT_LEN+1): registered count of pattern symbols currently matched.
REQ-012 SHALL have port match_cnt  output  CNT_W: registered, saturating count of matches.

Function
REQ-013 SHALL hold progress in the range 0..PAT_LEN-1; progress is the FSM state.
REQ-014 SHALL assert pattern combinationally only when rst=0, din_valid=1, progress=PAT_LEN-1, and din equals the last PATTERN symbol.
REQ-015 On a valid symbol that extends the match without completing it, progress SHALL increment by 1 at the next edge.
REQ-016 On a mismatching valid symbol, next progress SHALL be the length of the longest pattern prefix that is a suffix of the matched symbols followed by din (KMP failure rule).
REQ-017 The failure table SHALL be computed at elaboration from PATTERN; no runtime pattern load.
REQ-018 On a match with overlap_en=1, next progress SHALL be the longest proper prefix-suffix length of the full pattern.
REQ-019 On a match with overlap_en=0, next progress SHALL be 0.
REQ-020 When din_valid=0, progress and match_cnt SHALL hold, and pattern SHALL be 0.
REQ-021 overlap_en SHALL be sampled only in the cycle of a match; changing it mid-sequence SHALL not disturb progress.
REQ-022 match_cnt SHALL increment by 1 at the edge following each pattern assertion.
REQ-023 match_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-024 Unsupported parameter values (PAT_LEN or SYM_W out of range, wrong PATTERN width) SHALL cause an elaboration error.

Reset
REQ-025 While rst=1 at an edge: progress<=0 and match_cnt<=0.
REQ-026 While rst=1, pattern SHALL be 0 regardless of din.
REQ-027 Reset mid-sequence SHALL discard the partial match entirely.
REQ-028 The first symbol after reset deasserts SHALL be evaluated from progress 0.

Configuration
REQ-029 With macro SEQ_DETECT_PARAM_CNT_EN defined, the match_cnt register and its saturation logic SHALL be compiled in as in REQ-022 and REQ-023.
REQ-030 Without SEQ_DETECT_PARAM_CNT_EN, match_cnt SHALL be a constant 0 with no register, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Defaults, rst for 1 cycle, then valid din 0,0,1,1,1 -> pattern=1 in the 5th cycle only; match_cnt=1 after that edge (CNT_EN builds).
REQ-032 Defaults, din 0,0,0,1,1,1 -> progress 1,2,2,3,4; pattern=1 on the 6th symbol.
REQ-033 PAT_LEN=4, PATTERN=4'b0101, din 0,1,0,1,0,1:
  - overlap_en=1 -> pattern on symbols 4 and 6;
  - overlap_en=0 -> pattern on symbol 4 only.
REQ-034 Defaults, din 0,0, then din_valid=0 for 3 cycles, then 1,1,1 -> progress holds at 2 through the gap; pattern=1 on the final symbol; pattern=0 throughout the gap.
REQ-035 Defaults, din 0,0,1, then rst=1 for 1 cycle, then 1,1 -> progress=0 after rst; no pattern assertion.
REQ-036 CNT_W=2, 5 back-to-back matches -> match_cnt reads 1,2,3,3,3; with the macro undefined it reads 0 throughout.
